// File: rtl/jtgng_romload_pkg.sv
// Shared types and constants for the GnG ROM-load transmitter.
// Region bases are the offsets the download controller adds to form the base address.
package jtgng_romload_pkg;

    localparam int ROMLOAD_AW = 19;
    localparam int TIMER_W    = 8;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_FETCH,
        ST_SETUP,
        ST_STROBE,
        ST_GAP
    } state_e;

    typedef enum logic [2:0] {
        RGN_MAIN,
        RGN_SOUND,
        RGN_CHAR,
        RGN_SCROLL,
        RGN_OBJ
    } region_e;

    localparam logic [ROMLOAD_AW-1:0] BASE_MAIN   = 19'h00000;
    localparam logic [ROMLOAD_AW-1:0] BASE_SOUND  = 19'h18000;
    localparam logic [ROMLOAD_AW-1:0] BASE_CHAR   = 19'h20000;
    localparam logic [ROMLOAD_AW-1:0] BASE_SCROLL = 19'h24000;
    localparam logic [ROMLOAD_AW-1:0] BASE_OBJ    = 19'h44000;

    function automatic logic [ROMLOAD_AW-1:0] region_base(input region_e rgn);
        logic [ROMLOAD_AW-1:0] b;
        case (rgn)
            RGN_MAIN:   b = BASE_MAIN;
            RGN_SOUND:  b = BASE_SOUND;
            RGN_CHAR:   b = BASE_CHAR;
            RGN_SCROLL: b = BASE_SCROLL;
            RGN_OBJ:    b = BASE_OBJ;
            default:    b = BASE_MAIN;
        endcase
        return b;
    endfunction

endpackage

// File: rtl/jtgng_romload_timer.sv
// Down-counter shared by the SETUP/STROBE/GAP states; zero_o flags terminal count.
module jtgng_romload_timer #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load_i,
    input  logic [W-1:0] value_i,
    output logic         zero_o
);

    logic [W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = value_i;
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/jtgng_romload_tx.sv
// ROM-load transmitter: turns a host byte stream into timed romload write strobes
// at an auto-incrementing address, with progress, checksum and busy reporting.
//
// state     | meaning
// ST_IDLE   | waiting for start
// ST_FETCH  | in_ready high, waiting for a host byte
// ST_SETUP  | addr/data stable, wr low, SETUP cycles
// ST_STROBE | wr high for HOLD cycles
// ST_GAP    | wr low for max(GAP,1) cycles, then next byte or done
module jtgng_romload_tx
    import jtgng_romload_pkg::*;
#(
    parameter int AW    = ROMLOAD_AW,
    parameter int SETUP = 1,
    parameter int HOLD  = 2,
    parameter int GAP   = 1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start,
    input  logic          abort,
    input  logic [AW-1:0] base,
    input  logic [AW:0]   length,
    input  logic [7:0]    in_data,
    input  logic          in_valid,
    output logic          in_ready,
    output logic [AW-1:0] romload_addr,
    output logic [7:0]    romload_data,
    output logic          romload_wr,
    output logic          busy,
    output logic          done,
    output logic          aborted,
    output logic          wrap_err,
    output logic [15:0]   checksum,
    output logic [AW:0]   count
);

    localparam logic [TIMER_W-1:0] SETUP_LD = TIMER_W'(SETUP - 1);
    localparam logic [TIMER_W-1:0] HOLD_LD  = TIMER_W'(HOLD - 1);
    localparam logic [TIMER_W-1:0] GAP_LD   = TIMER_W'((GAP > 0) ? GAP - 1 : 0);

    state_e              state_q, state_d;
    logic [AW:0]         len_q, len_d;
    logic [AW:0]         count_q, count_d;
    logic [AW-1:0]       addr_q, addr_d;
    logic [7:0]          data_q, data_d;
    logic [15:0]         csum_q, csum_d;
    logic                wrap_q, wrap_d;
    logic                wr_q, wr_d;
    logic                done_q, done_d;
    logic                abrt_q, abrt_d;
    logic                tmr_load;
    logic [TIMER_W-1:0]  tmr_val;
    logic                tmr_zero;

    jtgng_romload_timer #(.W(TIMER_W)) u_timer (
        .clk     (clk),
        .rst_n   (rst_n),
        .load_i  (tmr_load),
        .value_i (tmr_val),
        .zero_o  (tmr_zero)
    );

    // Abort gates in_ready so a byte offered in the abort cycle is not consumed.
    assign in_ready = (state_q == ST_FETCH) && !abort;

    always_comb begin
        state_d  = state_q;
        len_d    = len_q;
        count_d  = count_q;
        addr_d   = addr_q;
        data_d   = data_q;
        csum_d   = csum_q;
        wrap_d   = wrap_q;
        done_d   = 1'b0;
        abrt_d   = 1'b0;
        tmr_load = 1'b0;
        tmr_val  = '0;

        case (state_q)
            ST_IDLE: begin
                if (start && !abort) begin
                    count_d = '0;
                    csum_d  = '0;
                    wrap_d  = 1'b0;
                    if (length == '0) begin
                        done_d = 1'b1;
                    end else begin
                        len_d   = length;
                        addr_d  = base;
                        state_d = ST_FETCH;
                    end
                end
            end
            ST_FETCH: begin
                if (in_valid) begin
                    data_d   = in_data;
                    tmr_load = 1'b1;
                    tmr_val  = SETUP_LD;
                    state_d  = ST_SETUP;
                end
            end
            ST_SETUP: begin
                if (tmr_zero) begin
                    tmr_load = 1'b1;
                    tmr_val  = HOLD_LD;
                    state_d  = ST_STROBE;
                end
            end
            ST_STROBE: begin
                if (tmr_zero) begin
                    count_d  = count_q + 1'b1;
                    csum_d   = csum_q + {8'd0, data_q};
                    // The write just finished at the top address: the next one wraps.
                    if (&addr_q) begin
                        wrap_d = 1'b1;
                    end
                    addr_d   = addr_q + 1'b1;
                    tmr_load = 1'b1;
                    tmr_val  = GAP_LD;
                    state_d  = ST_GAP;
                end
            end
            ST_GAP: begin
                if (tmr_zero) begin
                    if (count_q == len_q) begin
                        done_d  = 1'b1;
                        state_d = ST_IDLE;
                    end else begin
                        state_d = ST_FETCH;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase

        if (abort && (state_q != ST_IDLE)) begin
            state_d = ST_IDLE;
            abrt_d  = 1'b1;
            done_d  = 1'b0;
            count_d = count_q;
            csum_d  = csum_q;
            wrap_d  = wrap_q;
            addr_d  = addr_q;
        end

        wr_d = (state_d == ST_STROBE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            len_q   <= '0;
            count_q <= '0;
            addr_q  <= '0;
            data_q  <= '0;
            csum_q  <= '0;
            wrap_q  <= 1'b0;
            wr_q    <= 1'b0;
            done_q  <= 1'b0;
            abrt_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            len_q   <= len_d;
            count_q <= count_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
            csum_q  <= csum_d;
            wrap_q  <= wrap_d;
            wr_q    <= wr_d;
            done_q  <= done_d;
            abrt_q  <= abrt_d;
        end
    end

    assign romload_addr = addr_q;
    assign romload_data = data_q;
    assign romload_wr   = wr_q;
    assign busy         = (state_q != ST_IDLE);
    assign done         = done_q;
    assign aborted      = abrt_q;
    assign wrap_err     = wrap_q;
    assign checksum     = csum_q;
    assign count        = count_q;

endmodule
